fact_host_ctrl: RTL

//  Bus-master sequencer directly upstream of Top. It turns one command {operand, dst} into the full
//  m_* transaction sequence: clear, load operand, enable interrupt, start, await completion,

---
 rtl/fact_host_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fact_host_ctrl.sv
// Bus-master sequencer for the factorial core: turns one {operand, dst} command into the
// clear / load / start / wait / read / store / clear transaction sequence on the m_* bus.
module fact_host_ctrl #(
   parameter logic [19:0] TIMEOUT = 20'd1000000,
   parameter logic [15:0] A_START = 16'h7000,
   parameter logic [15:0] A_CLEAR = 16'h7008,
   parameter logic [15:0] A_DONE  = 16'h7010,
   parameter logic [15:0] A_INTEN = 16'h7018,
   parameter logic [15:0] A_OPND  = 16'h7020,
   parameter logic [15:0] A_RES_H = 16'h7028,
   parameter logic [15:0] A_RES_L = 16'h7030
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [63:0]  cmd_operand,
   input  logic [15:0]  cmd_dst,
   output logic         done,
   output logic         err,
   output logic [127:0] result,
   output logic         busy,
   output logic         m_req,
   output logic         m_wr,
   output logic [15:0]  m_addr,
   output logic [63:0]  m_dout,
   input  logic         m_grant,
   input  logic [63:0]  m_din,
   input  logic         interrupt
);

   typedef enum logic [3:0] {
      IDLE, REQ, CLR1, CLR0, WR_OP, WR_IE, START, WAIT,
      RD_H, RD_L, ST_H, ST_L, CLR_A, CLR_B, DONE
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [63:0] dout;
   } bus_t;

   localparam logic [15:0] DST_MAX = 16'h07FE;

   function automatic bus_t wr(input logic [15:0] a, input logic [63:0] d);
      return '{wr: 1'b1, addr: a, dout: d};
   endfunction

   function automatic bus_t rd(input logic [15:0] a);
      return '{wr: 1'b0, addr: a, dout: 64'd0};
   endfunction

   state_t       st_q;
   bus_t         bus_q;
   logic         m_req_q, cmd_ready_q, busy_q, done_q, err_q, tmo_q, ph_q;
   logic [63:0]  op_q, res_h_q, res_l_q;
   logic [15:0]  dst_q;
   logic [19:0]  cnt_q;
   logic [127:0] result_q;

   logic [19:0]  cnt_d;
   logic         cmpl_d, term_d, bad_dst_d;

   // ph_q marks that the previous cycle presented a granted read, so m_din is valid now
   assign cnt_d     = cnt_q + 20'd1;
   assign cmpl_d    = interrupt | (ph_q & m_din[0]);
   assign term_d    = (cnt_q == TIMEOUT - 20'd1);
   assign bad_dst_d = (cmd_dst > DST_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q        <= IDLE;
         bus_q       <= '0;
         m_req_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         ph_q        <= 1'b0;
         op_q        <= '0;
         dst_q       <= '0;
         res_h_q     <= '0;
         res_l_q     <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (st_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q        <= cmd_operand;
                  dst_q       <= cmd_dst;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  tmo_q       <= 1'b0;
                  if (bad_dst_d) begin
                     st_q     <= DONE;
                     done_q   <= 1'b1;
                     err_q    <= 1'b1;
                     result_q <= '0;
                  end else begin
                     st_q    <= REQ;
                     m_req_q <= 1'b1;
                     bus_q   <= '0;
                  end
               end
            end
            REQ: if (m_grant) begin
               st_q  <= CLR1;
               bus_q <= wr(A_CLEAR, 64'd1);
            end
            CLR1: if (m_grant) begin
               st_q  <= CLR0;
               bus_q <= wr(A_CLEAR, 64'd0);
            end
            CLR0: if (m_grant) begin
               st_q  <= WR_OP;
               bus_q <= wr(A_OPND, op_q);
            end
            WR_OP: if (m_grant) begin
               st_q  <= WR_IE;
               bus_q <= wr(A_INTEN, 64'd1);
            end
            WR_IE: if (m_grant) begin
               st_q  <= START;
               bus_q <= wr(A_START, 64'd1);
            end
            START: if (m_grant) begin
               st_q  <= WAIT;
               bus_q <= rd(A_DONE);
               cnt_q <= '0;
               ph_q  <= 1'b0;
            end
            WAIT: begin
               ph_q <= m_grant;
               // completion takes priority over the terminal count
               if (cmpl_d) begin
                  st_q  <= RD_H;
                  bus_q <= rd(A_RES_H);
                  ph_q  <= 1'b0;
               end else if (term_d) begin
                  st_q  <= CLR_A;
                  tmo_q <= 1'b1;
                  bus_q <= wr(A_CLEAR, 64'd1);
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RD_H: begin
               if (ph_q) begin
                  res_h_q <= m_din;
                  ph_q    <= 1'b0;
                  st_q    <= RD_L;
                  bus_q   <= rd(A_RES_L);
               end else if (m_grant) begin
                  ph_q <= 1'b1;
               end
            end
            RD_L: begin
               if (ph_q) begin
                  res_l_q <= m_din;
                  ph_q    <= 1'b0;
                  st_q    <= ST_H;
                  bus_q   <= wr(dst_q, res_h_q);
               end else if (m_grant) begin
                  ph_q <= 1'b1;
               end
            end
            ST_H: if (m_grant) begin
               st_q  <= ST_L;
               bus_q <= wr(dst_q + 16'd1, res_l_q);
            end
            ST_L: if (m_grant) begin
               st_q  <= CLR_A;
               bus_q <= wr(A_CLEAR, 64'd1);
            end
            CLR_A: if (m_grant) begin
               st_q  <= CLR_B;
               bus_q <= wr(A_CLEAR, 64'd0);
            end
            CLR_B: if (m_grant) begin
               st_q     <= DONE;
               bus_q    <= '0;
               m_req_q  <= 1'b0;
               done_q   <= 1'b1;
               err_q    <= tmo_q;
               result_q <= tmo_q ? 128'd0 : {res_h_q, res_l_q};
            end
            DONE: begin
               st_q        <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign m_req     = m_req_q;
   assign m_wr      = bus_q.wr;
   assign m_addr    = bus_q.addr;
   assign m_dout    = bus_q.dout;

endmodule
